// File: rtl/guia_check_pkg.sv
// guia_check_pkg: shared state encoding, settle limit and minterm-count helper for the sweep checker
package guia_check_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, COMPARE, DONE} state_t;
  localparam int MAX_SETTLE = 15;
  function automatic int minterms(input int n);
    return 1 << n;
  endfunction
endpackage

// File: rtl/settle_counter.sv
// settle_counter: 4-bit loadable down-counter that times how long each minterm is held before sampling
// ports: load_i/load_val_i reload, dec_i counts down (stops at 0), value_o current count, expired_o last settle cycle
module settle_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic [3:0] value_o,
  output logic       expired_o
);
  logic [3:0] value_q;
  always_ff @(posedge clk)
    if (reset) value_q <= '0;
    else if (load_i) value_q <= load_val_i;
    else if (dec_i && value_q != 4'd0) value_q <= value_q - 4'd1;
  assign value_o   = value_q;
  assign expired_o = value_q == 4'd1;
endmodule

// File: rtl/minterm_sweep_checker.sv
// minterm_sweep_checker: sweeps all minterms onto stim, compares ref_in vs dut_in, reports mismatches and the reference truth table
// ports: start kicks a sweep from IDLE; stim drives the functions; busy/done/pass report progress;
// mismatch_count/first_fail_valid/first_fail_m/ref_table hold the last sweep's results until the next start or reset
module minterm_sweep_checker
  import guia_check_pkg::*;
#(
  parameter int N_INPUTS      = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  output logic [N_INPUTS-1:0]           stim,
  input  logic                          ref_in,
  input  logic                          dut_in,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [N_INPUTS:0]             mismatch_count,
  output logic                          first_fail_valid,
  output logic [N_INPUTS-1:0]           first_fail_m,
  output logic [minterms(N_INPUTS)-1:0] ref_table
);
  localparam int M = minterms(N_INPUTS);
  localparam logic [3:0] S = 4'(SETTLE_CYCLES > MAX_SETTLE ? MAX_SETTLE : SETTLE_CYCLES);
  localparam logic [N_INPUTS-1:0] LAST = '1;
  // with no settle time the FSM stays in COMPARE and visits one minterm per cycle
  localparam state_t HOLD = S == 4'd0 ? COMPARE : SETTLE;
  state_t              state_q, state_d;
  logic [N_INPUTS-1:0] m_q, m_d, ffm_q, ffm_d;
  logic [N_INPUTS:0]   mm_q, mm_d;
  logic [M-1:0]        rt_q, rt_d;
  logic                ffv_q, ffv_d, pass_q, pass_d, load, expired, diff;
  logic [3:0]          cnt;
  settle_counter u_settle (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load),
    .load_val_i (S),
    .dec_i      (state_q == SETTLE && cnt != 4'd0),
    .value_o    (cnt),
    .expired_o  (expired)
  );
  assign diff = ref_in ^ dut_in;
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    mm_d    = mm_q;
    ffv_d   = ffv_q;
    ffm_d   = ffm_q;
    rt_d    = rt_q;
    pass_d  = pass_q;
    load    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        m_d     = '0;
        mm_d    = '0;
        ffv_d   = 1'b0;
        ffm_d   = '0;
        rt_d    = '0;
        pass_d  = 1'b0;
        load    = 1'b1;
        state_d = HOLD;
      end
      SETTLE: state_d = expired ? COMPARE : SETTLE;
      COMPARE: begin
        rt_d[m_q] = ref_in;
        mm_d      = diff ? mm_q + 1'b1 : mm_q;
        if (diff && !ffv_q) begin
          ffv_d = 1'b1;
          ffm_d = m_q;
        end
        // pass must include the verdict of this final compare, so it uses mm_d
        if (m_q == LAST) begin
          state_d = DONE;
          pass_d  = mm_d == '0;
        end else begin
          m_d     = m_q + 1'b1;
          load    = 1'b1;
          state_d = HOLD;
        end
      end
      default: begin
        m_d     = '0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      m_q     <= '0;
      mm_q    <= '0;
      ffv_q   <= 1'b0;
      ffm_q   <= '0;
      rt_q    <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      mm_q    <= mm_d;
      ffv_q   <= ffv_d;
      ffm_q   <= ffm_d;
      rt_q    <= rt_d;
      pass_q  <= pass_d;
    end
  assign stim             = m_q;
  assign busy             = state_q == SETTLE || state_q == COMPARE;
  assign done             = state_q == DONE;
  assign pass             = pass_q;
  assign mismatch_count   = mm_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_m     = ffm_q;
  assign ref_table        = rt_q;
endmodule

// File: tb/tb_minterm_sweep_checker.sv
// tb_minterm_sweep_checker: scoreboard bench for three checker configurations (N2/S1, N2/S0, N3/S2)
module tb_minterm_sweep_checker;
  logic clk = 0, reset = 1, start = 0;
  int   sel = 0, mode = 0;
  int   vectors = 0, miscompares = 0;
  always #5 clk = ~clk;

  typedef struct {int lat; bit pass; int mm; bit ffv; int ffm; logic [7:0] rt;} exp_t;
  exp_t sb[$];

  function automatic bit ref_f(input int s, input int m);
    if (s == 2) return (m[2] & m[1]) | (m[2] & m[0]) | (m[1] & m[0]);
    return !(m[1] || !m[0]);
  endfunction
  function automatic bit dut_f(input int s, input int md, input int m);
    return md == 0 ? ref_f(s, m) : md == 1 ? !ref_f(s, m) : 1'b0;
  endfunction
  function automatic int settle_of(input int s);
    return s == 0 ? 1 : s == 1 ? 0 : 2;
  endfunction

  logic [1:0] stim_a, stim_b, ffm_a, ffm_b;
  logic [2:0] stim_c, ffm_c, mm_a, mm_b;
  logic [3:0] mm_c, rt_a, rt_b;
  logic [7:0] rt_c;
  logic busy_a, busy_b, busy_c, done_a, done_b, done_c, pass_a, pass_b, pass_c, ffv_a, ffv_b, ffv_c;
  logic ref_a, ref_b, ref_c, dut_a, dut_b, dut_c;
  assign ref_a = ref_f(0, int'(stim_a));
  assign dut_a = dut_f(0, mode, int'(stim_a));
  assign ref_b = ref_f(1, int'(stim_b));
  assign dut_b = dut_f(1, mode, int'(stim_b));
  assign ref_c = ref_f(2, int'(stim_c));
  assign dut_c = dut_f(2, mode, int'(stim_c));

  minterm_sweep_checker #(.N_INPUTS(2), .SETTLE_CYCLES(1)) dut_n2s1 (
    .clk(clk), .reset(reset), .start(start && sel == 0), .stim(stim_a), .ref_in(ref_a), .dut_in(dut_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .mismatch_count(mm_a),
    .first_fail_valid(ffv_a), .first_fail_m(ffm_a), .ref_table(rt_a));
  minterm_sweep_checker #(.N_INPUTS(2), .SETTLE_CYCLES(0)) dut_n2s0 (
    .clk(clk), .reset(reset), .start(start && sel == 1), .stim(stim_b), .ref_in(ref_b), .dut_in(dut_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .mismatch_count(mm_b),
    .first_fail_valid(ffv_b), .first_fail_m(ffm_b), .ref_table(rt_b));
  minterm_sweep_checker #(.N_INPUTS(3), .SETTLE_CYCLES(2)) dut_n3s2 (
    .clk(clk), .reset(reset), .start(start && sel == 2), .stim(stim_c), .ref_in(ref_c), .dut_in(dut_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .mismatch_count(mm_c),
    .first_fail_valid(ffv_c), .first_fail_m(ffm_c), .ref_table(rt_c));

  logic [2:0] stim_s, ffm_s;
  logic [3:0] mm_s;
  logic [7:0] rt_s;
  logic busy_s, done_s, pass_s, ffv_s;
  assign stim_s = sel == 0 ? {1'b0, stim_a} : sel == 1 ? {1'b0, stim_b} : stim_c;
  assign ffm_s  = sel == 0 ? {1'b0, ffm_a} : sel == 1 ? {1'b0, ffm_b} : ffm_c;
  assign mm_s   = sel == 0 ? {1'b0, mm_a} : sel == 1 ? {1'b0, mm_b} : mm_c;
  assign rt_s   = sel == 0 ? {4'b0, rt_a} : sel == 1 ? {4'b0, rt_b} : rt_c;
  assign busy_s = sel == 0 ? busy_a : sel == 1 ? busy_b : busy_c;
  assign done_s = sel == 0 ? done_a : sel == 1 ? done_b : done_c;
  assign pass_s = sel == 0 ? pass_a : sel == 1 ? pass_b : pass_c;
  assign ffv_s  = sel == 0 ? ffv_a : sel == 1 ? ffv_b : ffv_c;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected(input int s, input int md);
    exp_t e;
    int n = s == 2 ? 3 : 2;
    int st = settle_of(s);
    e.lat = 1 + (1 << n) * (st + 1);
    e.mm = 0; e.ffv = 0; e.ffm = 0; e.rt = '0;
    for (int m = (1 << n) - 1; m >= 0; m--) begin
      e.rt[m] = ref_f(s, m);
      if (ref_f(s, m) != dut_f(s, md, m)) begin
        e.mm++;
        e.ffv = 1;
        e.ffm = m;
      end
    end
    e.pass = e.mm == 0;
    sb.push_back(e);
  endtask

  task automatic sweep(input int s, input int md, input int restart_cyc, input bit start_in_done);
    exp_t e;
    int cyc, st, last;
    sel = s; mode = md; st = settle_of(s); last = (s == 2) ? 7 : 3;
    push_expected(s, md);
    start = 1; tick; start = 0; cyc = 1;
    while (done_s !== 1'b1 && cyc < 200) begin
      vectors++;
      if (busy_s !== 1'b1 || stim_s !== 3'((cyc - 1) / (st + 1))) begin
        miscompares++;
        $display("FAIL busy_stim sel=%0d cyc=%0d got busy=%b stim=%0d want busy=1 stim=%0d", s, cyc, busy_s, stim_s, (cyc - 1) / (st + 1));
      end
      start = (cyc == restart_cyc);
      tick; cyc++;
    end
    start = 0;
    e = sb.pop_front();
    vectors++;
    if (cyc !== e.lat) begin miscompares++; $display("FAIL latency sel=%0d got %0d want %0d", s, cyc, e.lat); end
    vectors++;
    if (done_s !== 1'b1 || busy_s !== 1'b0 || stim_s !== 3'(last)) begin
      miscompares++; $display("FAIL done_cycle sel=%0d got done=%b busy=%b stim=%0d want 1 0 %0d", s, done_s, busy_s, stim_s, last);
    end
    vectors++;
    if (pass_s !== e.pass) begin miscompares++; $display("FAIL pass sel=%0d got %b want %b", s, pass_s, e.pass); end
    vectors++;
    if (mm_s !== 4'(e.mm)) begin miscompares++; $display("FAIL mismatch_count sel=%0d got %0d want %0d", s, mm_s, e.mm); end
    vectors++;
    if (ffv_s !== e.ffv || ffm_s !== 3'(e.ffm)) begin
      miscompares++; $display("FAIL first_fail sel=%0d got v=%b m=%0d want v=%b m=%0d", s, ffv_s, ffm_s, e.ffv, e.ffm);
    end
    vectors++;
    if (rt_s !== e.rt) begin miscompares++; $display("FAIL ref_table sel=%0d got %b want %b", s, rt_s, e.rt); end
    start = start_in_done; tick; start = 0;
    vectors++;
    if (busy_s !== 1'b0 || done_s !== 1'b0 || stim_s !== 3'd0 || pass_s !== e.pass || mm_s !== 4'(e.mm)) begin
      miscompares++;
      $display("FAIL idle_hold sel=%0d got busy=%b done=%b stim=%0d pass=%b mm=%0d want 0 0 0 %b %0d", s, busy_s, done_s, stim_s, pass_s, mm_s, e.pass, e.mm);
    end
    tick;
  endtask

  task automatic test_reset;
    reset = 1; start = 1; sel = 0; tick; tick;
    vectors++;
    if ({busy_s, done_s, pass_s, ffv_s, stim_s, mm_s, ffm_s, rt_s} !== '0) begin
      miscompares++;
      $display("FAIL reset_values got busy=%b done=%b pass=%b ffv=%b stim=%0d mm=%0d ffm=%0d rt=%b want all 0", busy_s, done_s, pass_s, ffv_s, stim_s, mm_s, ffm_s, rt_s);
    end
    start = 0; reset = 0; tick;
    vectors++;
    if (busy_s !== 1'b0) begin miscompares++; $display("FAIL reset_beats_start got busy=%b want 0", busy_s); end
  endtask

  task automatic test_reset_mid;
    bit bad = 0;
    sel = 0; mode = 1;
    start = 1; tick; start = 0;
    repeat (3) tick;
    reset = 1; tick; reset = 0;
    vectors++;
    if (busy_s !== 1'b0 || stim_s !== 3'd0 || mm_s !== 4'd0 || done_s !== 1'b0 || ffv_s !== 1'b0 || rt_s !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_mid got busy=%b stim=%0d mm=%0d done=%b ffv=%b rt=%b want all 0", busy_s, stim_s, mm_s, done_s, ffv_s, rt_s);
    end
    for (int i = 0; i < 12; i++) begin
      if (done_s !== 1'b0 || busy_s !== 1'b0) bad = 1;
      tick;
    end
    vectors++;
    if (bad) begin miscompares++; $display("FAIL reset_mid_quiet got done/busy activity want none"); end
    sweep(0, 0, 0, 0);
  endtask

  initial begin
    test_reset;
    sweep(0, 0, 0, 0);
    sweep(0, 1, 0, 0);
    sweep(1, 2, 0, 0);
    sweep(0, 0, 3, 0);
    test_reset_mid;
    sweep(2, 0, 0, 0);
    sweep(2, 1, 0, 1);
    sweep(1, 0, 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
